// File: rtl/rx_word_aligner_20b.sv
// rx_word_aligner_20b: finds the K28.5 comma at any of 20 bit offsets, qualifies lock,
// and emits 20-bit words with the comma in bits 9:0.
module rx_word_aligner_20b #(
  parameter int VERIFY_CNT = 3,
  parameter int LOSS_CNT = 4,
  parameter logic [9:0] COMMA_P = 10'b0011111010,
  parameter logic [9:0] COMMA_N = 10'b1100000101
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        realign,
  input  logic        din_valid,
  input  logic [19:0] din,
  output logic [19:0] dout,
  output logic        dout_valid,
  output logic        locked,
  output logic [4:0]  align_off,
  output logic        comma_det
);
  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;
  localparam logic [3:0] VC = 4'(VERIFY_CNT);
  localparam logic [3:0] LC = 4'(LOSS_CNT);
  state_t state, nxt_state;
  logic [19:0] prev, hit;
  logic [39:0] w, sh;
  logic [3:0] cnt, miss_cnt, nxt_cnt, nxt_miss;
  logic [4:0] nxt_off, first_p;
  logic any_hit, hit_off;
  assign w = {din, prev};
  assign any_hit = |hit;
  assign hit_off = hit[align_off];
  assign sh = w >> nxt_off;
  always_comb begin
    hit = '0;
    first_p = '0;
    for (int p = 19; p >= 0; p--) begin
      hit[p] = (w[p +: 10] == COMMA_P) || (w[p +: 10] == COMMA_N);
      if (hit[p]) first_p = 5'(p);
    end
  end
  // align_off doubles as the working offset register
  always_comb begin
    nxt_state = state;
    nxt_off = align_off;
    nxt_cnt = cnt;
    nxt_miss = miss_cnt;
    if (realign) begin
      nxt_state = HUNT;
      nxt_cnt = '0;
      nxt_miss = '0;
    end else if (din_valid && any_hit) begin
      case (state)
        HUNT: begin
          nxt_off = first_p;
          nxt_cnt = 4'd1;
          nxt_miss = '0;
          nxt_state = (VC == 4'd1) ? LOCKED : VERIFY;
        end
        VERIFY: begin
          if (hit_off) begin
            nxt_cnt = cnt + 4'd1;
            if (cnt + 4'd1 == VC) begin
              nxt_state = LOCKED;
              nxt_miss = '0;
            end
          end else begin
            nxt_off = first_p;
            nxt_cnt = 4'd1;
          end
        end
        LOCKED: begin
          nxt_miss = hit_off ? 4'd0 : miss_cnt + 4'd1;
          if (!hit_off && miss_cnt + 4'd1 == LC) begin
            nxt_state = HUNT;
            nxt_cnt = '0;
            nxt_miss = '0;
          end
        end
        default: nxt_state = HUNT;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= HUNT;
      prev <= '0;
      dout <= '0;
      align_off <= '0;
      cnt <= '0;
      miss_cnt <= '0;
      dout_valid <= 1'b0;
      locked <= 1'b0;
      comma_det <= 1'b0;
    end else begin
      state <= nxt_state;
      align_off <= nxt_off;
      cnt <= nxt_cnt;
      miss_cnt <= nxt_miss;
      locked <= nxt_state == LOCKED;
      dout_valid <= din_valid && nxt_state == LOCKED;
      comma_det <= din_valid && hit[nxt_off];
      if (din_valid) begin
        prev <= din;
        dout <= sh[19:0];
      end
    end
  end
endmodule

// File: tb/tb_rx_word_aligner_20b.sv
// tb_rx_word_aligner_20b: directed scenarios on a bit stream shifted by a chosen offset.
module tb_rx_word_aligner_20b;
  localparam logic [9:0] CP = 10'b0011111010;
  localparam logic [19:0] K = {10'h2AA, CP};
  localparam logic [19:0] D1 = 20'hAAAAA;
  localparam logic [19:0] D2 = 20'h55555;
  logic clk = 1'b0, rst = 1'b0, realign = 1'b0, din_valid = 1'b0;
  logic [19:0] din = '0, dout, last = '0;
  logic dout_valid, locked, comma_det;
  logic [4:0] align_off;
  int n_cmp = 0, n_bad = 0, sft = 0;

  always #5 clk = ~clk;

  rx_word_aligner_20b dut (
    .clk(clk), .rst(rst), .realign(realign), .din_valid(din_valid), .din(din),
    .dout(dout), .dout_valid(dout_valid), .locked(locked), .align_off(align_off),
    .comma_det(comma_det)
  );

  task cyc(input logic [19:0] d, input logic v, input logic ra);
    din = d;
    din_valid = v;
    realign = ra;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    realign = 1'b0;
  endtask

  // Present the next original word delayed by sft bits in the serial stream.
  task sw(input logic [19:0] word);
    logic [39:0] t;
    t = {word, last} >> (20 - sft);
    last = word;
    cyc(t[19:0], 1'b1, 1'b0);
  endtask

  task idle();
    cyc(20'hFFFFF, 1'b0, 1'b0);
  endtask

  task restart(input int s);
    rst = 1'b0;
    #2;
    rst = 1'b1;
    sft = s;
    last = '0;
  endtask

  task test_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cyc(20'($urandom), 1'b1, 1'b0);
    n_cmp++; if (dout !== 20'h0) begin n_bad++; $display("FAIL rst_dout: got %h want 0", dout); end
    n_cmp++; if (dout_valid !== 1'b0) begin n_bad++; $display("FAIL rst_dout_valid: got %b want 0", dout_valid); end
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL rst_locked: got %b want 0", locked); end
    n_cmp++; if (align_off !== 5'd0) begin n_bad++; $display("FAIL rst_align_off: got %0d want 0", align_off); end
    n_cmp++; if (comma_det !== 1'b0) begin n_bad++; $display("FAIL rst_comma_det: got %b want 0", comma_det); end
    rst = 1'b1;
    sft = 0;
    last = '0;
    sw(K);
    sw(K);
    n_cmp++; if (comma_det !== 1'b1) begin n_bad++; $display("FAIL al0_first_comma: got %b want 1", comma_det); end
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL al0_early_lock: got %b want 0", locked); end
    sw(K);
    sw(D1);
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL al0_locked: got %b want 1", locked); end
    n_cmp++; if (dout_valid !== 1'b1) begin n_bad++; $display("FAIL al0_dout_valid: got %b want 1", dout_valid); end
    n_cmp++; if (dout !== K) begin n_bad++; $display("FAIL al0_dout: got %h want %h", dout, K); end
    n_cmp++; if (align_off !== 5'd0) begin n_bad++; $display("FAIL al0_align_off: got %0d want 0", align_off); end
    n_cmp++; if (comma_det !== 1'b1) begin n_bad++; $display("FAIL al0_comma_det: got %b want 1", comma_det); end
    sw(D2);
    n_cmp++; if (dout !== D1) begin n_bad++; $display("FAIL al0_data: got %h want %h", dout, D1); end
    n_cmp++; if (comma_det !== 1'b0) begin n_bad++; $display("FAIL al0_data_comma: got %b want 0", comma_det); end
  endtask

  task test_offset7();
    logic [19:0] orig [14];
    restart(7);
    for (int j = 0; j < 14; j++) orig[j] = (j % 4 == 0) ? K : (j % 4 == 2) ? D2 : D1;
    for (int j = 0; j < 14; j++) begin
      sw(orig[j]);
      if (j >= 1) begin
        n_cmp++; if (align_off !== 5'd7) begin n_bad++; $display("FAIL off7_align_off[%0d]: got %0d want 7", j, align_off); end
        n_cmp++; if (locked !== (j >= 9)) begin n_bad++; $display("FAIL off7_locked[%0d]: got %b want %b", j, locked, j >= 9); end
        n_cmp++; if (dout_valid !== (j >= 9)) begin n_bad++; $display("FAIL off7_valid[%0d]: got %b want %b", j, dout_valid, j >= 9); end
        n_cmp++; if (comma_det !== (orig[j-1] == K)) begin n_bad++; $display("FAIL off7_comma[%0d]: got %b want %b", j, comma_det, orig[j-1] == K); end
        if (j >= 9) begin
          n_cmp++; if (dout !== orig[j-1]) begin n_bad++; $display("FAIL off7_dout[%0d]: got %h want %h", j, dout, orig[j-1]); end
        end
      end
    end
  endtask

  task test_offset_change();
    restart(7);
    sw(K); sw(D1); sw(K); sw(D1);
    n_cmp++; if (align_off !== 5'd7) begin n_bad++; $display("FAIL chg_off7: got %0d want 7", align_off); end
    sft = 12;
    sw(K); sw(D1);
    n_cmp++; if (align_off !== 5'd12) begin n_bad++; $display("FAIL chg_off12: got %0d want 12", align_off); end
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL chg_lock1: got %b want 0", locked); end
    n_cmp++; if (dout !== K) begin n_bad++; $display("FAIL chg_dout: got %h want %h", dout, K); end
    sw(K); sw(D1);
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL chg_lock2: got %b want 0", locked); end
    sw(K); sw(D1);
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL chg_lock3: got %b want 1", locked); end
    n_cmp++; if (dout_valid !== 1'b1) begin n_bad++; $display("FAIL chg_valid: got %b want 1", dout_valid); end
    n_cmp++; if (align_off !== 5'd12) begin n_bad++; $display("FAIL chg_off_final: got %0d want 12", align_off); end
  endtask

  task test_loss();
    restart(0);
    repeat (3) begin sw(K); sw(D1); end
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL loss_lock: got %b want 1", locked); end
    sft = 5;
    repeat (3) begin sw(K); sw(D1); end
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL loss_hold3: got %b want 1", locked); end
    sw(K); sw(D1);
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL loss_drop: got %b want 0", locked); end
    n_cmp++; if (dout_valid !== 1'b0) begin n_bad++; $display("FAIL loss_valid: got %b want 0", dout_valid); end
    n_cmp++; if (align_off !== 5'd0) begin n_bad++; $display("FAIL loss_off_hold: got %0d want 0", align_off); end
    restart(0);
    repeat (3) begin sw(K); sw(D1); end
    sft = 5;
    repeat (3) begin sw(K); sw(D1); end
    sft = 0;
    sw(K); sw(D1);
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL loss_reclaim: got %b want 1", locked); end
    sft = 5;
    repeat (3) begin sw(K); sw(D1); end
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL loss_miss_cleared: got %b want 1", locked); end
    n_cmp++; if (dout_valid !== 1'b1) begin n_bad++; $display("FAIL loss_miss_valid: got %b want 1", dout_valid); end
  endtask

  task test_realign();
    restart(0);
    repeat (3) begin sw(K); sw(D1); end
    sw(K);
    last = D1;
    cyc(D1, 1'b1, 1'b1);
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL ra_locked: got %b want 0", locked); end
    n_cmp++; if (dout_valid !== 1'b0) begin n_bad++; $display("FAIL ra_valid: got %b want 0", dout_valid); end
    n_cmp++; if (comma_det !== 1'b1) begin n_bad++; $display("FAIL ra_comma: got %b want 1", comma_det); end
    repeat (2) begin sw(K); sw(D1); end
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL ra_relock_early: got %b want 0", locked); end
    sw(K); sw(D1);
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL ra_relock: got %b want 1", locked); end
  endtask

  task test_gaps();
    restart(7);
    for (int i = 0; i < 3; i++) begin
      sw(K);
      idle();
      sw(D1);
      n_cmp++; if (locked !== (i == 2)) begin n_bad++; $display("FAIL gap_locked[%0d]: got %b want %b", i, locked, i == 2); end
      if (i < 2) begin
        idle();
        n_cmp++; if (dout_valid !== 1'b0) begin n_bad++; $display("FAIL gap_idle_valid[%0d]: got %b want 0", i, dout_valid); end
      end
    end
    n_cmp++; if (dout !== K) begin n_bad++; $display("FAIL gap_dout: got %h want %h", dout, K); end
    n_cmp++; if (dout_valid !== 1'b1) begin n_bad++; $display("FAIL gap_valid: got %b want 1", dout_valid); end
    idle();
    n_cmp++; if (dout_valid !== 1'b0) begin n_bad++; $display("FAIL gap_idle_locked_valid: got %b want 0", dout_valid); end
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL gap_idle_locked: got %b want 1", locked); end
    sw(D2);
    n_cmp++; if (dout !== D1) begin n_bad++; $display("FAIL gap_resume_dout: got %h want %h", dout, D1); end
    n_cmp++; if (dout_valid !== 1'b1) begin n_bad++; $display("FAIL gap_resume_valid: got %b want 1", dout_valid); end
    #2;
    rst = 1'b0;
    #1;
    n_cmp++; if (dout !== 20'h0) begin n_bad++; $display("FAIL arst_dout: got %h want 0", dout); end
    n_cmp++; if (dout_valid !== 1'b0) begin n_bad++; $display("FAIL arst_valid: got %b want 0", dout_valid); end
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL arst_locked: got %b want 0", locked); end
    n_cmp++; if (align_off !== 5'd0) begin n_bad++; $display("FAIL arst_align_off: got %0d want 0", align_off); end
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_offset7();
    test_offset_change();
    test_loss();
    test_realign();
    test_gaps();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rx_word_aligner_20b.md
Name: rx_word_aligner_20b

Overview:
Receive-side word aligner placed in front of the 16B/20B decoder. It takes unaligned 20-bit words from the deserializer and searches every bit offset for the 8B/10B K28.5 comma. A lock state machine qualifies the alignment, and the block outputs 20-bit words aligned so the comma falls in the low symbol (bits 9:0). This is the symbol boundary the decoder expects from the 16B/20B encoder, whose transmit side places K28.5 in the low symbol.

Parameters:
VERIFY_CNT, 3, number of consecutive commas at the same offset needed to declare lock (1..15)
LOSS_CNT, 4, number of consecutive commas seen at a different offset while locked that forces loss of lock (1..15)
COMMA_P, 10'b0011111010, K28.5 RD- code, in the same bit order as the codec's 10-bit symbols
COMMA_N, 10'b1100000101, K28.5 RD+ code

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
realign  input  1  synchronous pulse; forces the FSM back to HUNT
din_valid  input  1  din is valid this cycle
din  input  20  unaligned deserialized word; bit 0 is the oldest received bit
dout  output  20  aligned word, fed to the decoder input
dout_valid  output  1  dout is valid and the aligner is locked
locked  output  1  FSM is in LOCKED
align_off  output  5  current bit offset, 0..19
comma_det  output  1  the word on dout has a comma at bits 9:0

Behaviour:
- Reset (rst=0, asynchronous): state=HUNT; prev, dout, align_off, cnt and miss_cnt = 0; dout_valid, locked and comma_det = 0.
- Only cycles with din_valid=1 update anything. On din_valid=0 all state holds and dout_valid=0 next cycle.
- Window: w[39:0] = {din, prev}, then prev <= din. The first valid word after reset is windowed with prev=0.
- hit[p] for p=0..19: w[p+9:p] equals COMMA_P or COMMA_N. first_p = lowest p with hit set. any_hit = OR of hit.
- HUNT:
  - any_hit → off <= first_p, cnt <= 1; go to VERIFY, or directly to LOCKED if VERIFY_CNT=1.
  - No hit → stay in HUNT.
- VERIFY:
  - hit[off] → cnt+1; when cnt+1 == VERIFY_CNT, go to LOCKED and clear miss_cnt.
  - any_hit but not hit[off] → off <= first_p, cnt <= 1.
  - No hit → hold.
- LOCKED:
  - hit[off] → miss_cnt <= 0.
  - any_hit but not hit[off] → miss_cnt+1; when it reaches LOSS_CNT, go to HUNT with cnt=0 (off holds until the next hit).
  - No hit → hold (data words are legal).
- realign=1 overrides all transitions: next state=HUNT, cnt and miss_cnt cleared. It takes priority over a simultaneous comma.
- Output timing: all outputs are registered with 1-cycle latency and use the post-update offset and state (nxt_off, nxt_state):
  - dout <= w[nxt_off+19 : nxt_off]
  - dout_valid <= din_valid & (nxt_state==LOCKED)
  - comma_det <= din_valid & hit[nxt_off]
  - locked <= (nxt_state==LOCKED)
  - align_off <= nxt_off
- Because of this, the word that completes verification is itself emitted aligned and valid.
- dout is updated on every valid cycle, even when not locked; the decoder must qualify it with dout_valid.
- Counters saturate at their thresholds and never wrap.
- An offset of 0 with a comma in din[9:0] means the input is already aligned: dout equals the previous-cycle din at zero added latency beyond the 1 register stage.

Test Plan:
- Reset: hold rst=0 with random din → dout=0, dout_valid=0, locked=0, align_off=0. Release, then feed three aligned K28.5 words (din[9:0]=COMMA_P) → locked=1 on the 3rd word's output cycle, align_off=0, comma_det=1.
- Offset 7: feed a stream shifted left by 7 bits, with a comma every 4th word and data words in between → align_off=7 after the first comma; locked after the 3rd comma; dout reproduces the original unshifted words from then on.
- Offset change during VERIFY: 2 commas at offset 7, then a comma at offset 12 → align_off=12, cnt restarts; lock only after 3 commas at 12.
- Loss of lock: lock at offset 0, then 4 consecutive commas at offset 5 → locked drops on the 4th. With only 3 misaligned commas followed by one at offset 0, lock is held and miss_cnt clears.
- realign asserted together with an aligned comma while LOCKED → next cycle locked=0, dout_valid=0; lock is regained after 3 more commas.
- din_valid gaps: insert idle cycles between the verify commas → dout_valid stays 0 on idle cycles; lock is still reached after 3 valid commas; async rst mid-stream clears all outputs immediately.
